dual_fetch_queue: RTL
=====================

// Module: dual_fetch_queue
// PURPOSE
//   Dual-wide instruction fetch stage feeding the dual-issue/scoreboard stage of top_processor.
//   Each cycle it fetches an instruction pair (PC, PC+4) from the combinational two-port imem.
//   Fetched pairs are buffered in an in-order FIFO. The issue stage consumes 0, 1 or 2 per cycle.
//   This decouples scoreboard stalls from fetch. A redirect flushes the queue and restarts fetch.
// PARAMETERS
//   DEPTH     8              queue capacity in single instructions; power of 2, >= 4
//   RESET_PC  32'h00000000   fetch PC loaded on reset
//   NOP_INSTR 32'h00000013   value driven on issue_instrN when issue_validN = 0
// PORTS
//   clk            in   1   clock, all state updates on rising edge
//   reset          in   1   synchronous, active-high reset
//   imem_addr0     out  32  fetch address, slot 0 (= fetch_pc)
//   imem_addr1     out  32  fetch address, slot 1 (= fetch_pc + 4)
//   imem_data0     in   32  instruction at imem_addr0, valid same cycle (combinational ROM)
//   imem_data1     in   32  instruction at imem_addr1, valid same cycle
//   redirect_valid in   1   flush queue and restart fetch at redirect_pc
//   redirect_pc    in   32  new fetch PC; bits [1:0] forced to 0
//   issue_take     in   2   instructions consumed this cycle (0/1/2); clipped to occupancy, 3 treated as 2
//   issue_valid0   out  1   queue head valid
//   issue_instr0   out  32  head instruction
//   issue_pc0      out  32  head PC
//   issue_valid1   out  1   head+1 valid
//   issue_instr1   out  32  head+1 instruction
//   issue_pc1      out  32  head+1 PC
//   occupancy      out  $clog2(DEPTH)+1  instructions currently queued
//   debug_fetch_pc out  32  current fetch PC
// BEHAVIOUR
//   - Reset: fetch_pc=RESET_PC, head/tail pointers=0, occupancy=0, both valids=0.
//     On reset, issue_instrN=NOP_INSTR and issue_pcN=0. Reset overrides redirect and take.
//   - imem_addr0/1 are combinational from fetch_pc. PC arithmetic wraps modulo 2^32.
//   - Issue outputs are combinational from queue storage: valid0=(occ>=1), valid1=(occ>=2).
//   - Dequeue: eff_take = min(issue_take clipped to 2, occ). The head advances by eff_take.
//   - Enqueue rule: if (occ - eff_take) <= DEPTH-2, write {imem_data0,fetch_pc} then
//     {imem_data1,fetch_pc+4} at tail and tail+1. Then tail += 2 and fetch_pc += 8.
//     Otherwise there is no enqueue and fetch_pc holds (imem addresses stay stable).
//   - Same-cycle dequeue and enqueue are both applied: occ_next = occ - eff_take + 2*enq.
//     Enqueue may therefore use slots freed by that cycle's dequeue.
//   - Latency: a pair fetched in cycle N is visible at the issue outputs in cycle N+1 (empty queue).
//   - Order: strictly in program order; no duplication or loss across pointer wrap.
//     Pointers are $clog2(DEPTH) bits and wrap naturally.
//   - Redirect (no reset): occ=0, head=tail=0, fetch_pc=redirect_pc&~3.
//     During redirect there is no enqueue and issue_take is ignored.
//     In the next cycle both valids=0 and imem_addr0=redirect target.
//   - Slot 1 is always fetch_pc+4; no 8-byte alignment requirement.
//   - Full queue with take=0: state frozen indefinitely.
//     Empty queue with take>0: no-op, fetch proceeds normally.
// TESTING
//   1 Reset, ROM[i]=i+1, take=0: cycle after reset release valid0/1=1, instr0=1 pc0=0, instr1=2 pc1=4.
//   2 take=0 held: enqueues for 4 cycles, occupancy=8, debug_fetch_pc=32 held, imem_addr0/1=32/36 stable.
//   3 Full queue, take=1 every cycle: occupancy alternates 7/8; issued PCs 0,4,8,... with no gaps or repeats.
//   4 take=2 every cycle for 20 cycles: steady occupancy=2, issue_pc0 advances by 8 per cycle.
//     Correct across pointer wrap.
//   5 Full queue, redirect_valid=1 redirect_pc=0x42: next cycle valids=0, occupancy=0, imem_addr0=0x40.
//     The following cycle instr0=ROM[16].
//   6 Mid-run reset=1 with redirect_valid=1 and take=2: next cycle debug_fetch_pc=RESET_PC,
//     occupancy=0, issue_instr0=NOP_INSTR.

Source files
------------

// File: rtl/dual_fetch_queue.sv
// ---------------------------------------------------------------------------
// dual_fetch_queue
//   Dual-wide instruction fetch stage. Every cycle that the queue has room for
//   two more entries, the instruction pair at (fetch_pc, fetch_pc+4) is read
//   from a combinational two-port imem and appended to an in-order FIFO. The
//   issue stage reads the two oldest entries and consumes 0, 1 or 2 per cycle.
//   A redirect empties the queue and restarts fetch at the new PC.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   imem_addr0/1                fetch addresses (fetch_pc, fetch_pc+4)
//   imem_data0/1                instructions returned for those addresses
//   redirect_valid/redirect_pc  flush and restart fetch (pc[1:0] dropped)
//   issue_take                  instructions consumed this cycle (3 acts as 2)
//   issue_valid/instr/pc 0..1   head and head+1 of the queue
//   occupancy                   instructions currently queued
//   debug_fetch_pc              current fetch PC
// ---------------------------------------------------------------------------
module dual_fetch_queue #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [31:0]                imem_addr0,
    output logic [31:0]                imem_addr1,
    input  logic [31:0]                imem_data0,
    input  logic [31:0]                imem_data1,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic [1:0]                 issue_take,
    output logic                       issue_valid0,
    output logic [31:0]                issue_instr0,
    output logic [31:0]                issue_pc0,
    output logic                       issue_valid1,
    output logic [31:0]                issue_instr1,
    output logic [31:0]                issue_pc1,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [31:0]                debug_fetch_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    // Queue storage carries data only, so it is left out of reset.
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [OW-1:0] occ;
    logic [31:0]   fetch_pc;

    logic [1:0]    take_clip;
    logic [OW-1:0] eff_take;
    logic [OW-1:0] occ_after;
    logic          enq;
    logic [PW-1:0] head1;
    logic [PW-1:0] tail1;

    assign imem_addr0     = fetch_pc;
    assign imem_addr1     = fetch_pc + 32'd4;
    assign debug_fetch_pc = fetch_pc;
    assign occupancy      = occ;

    assign head1 = head + PW'(1);
    assign tail1 = tail + PW'(1);

    // The enqueue check is made against the occupancy left after this cycle's
    // dequeue, so slots freed by the issue stage can be refilled immediately.
    always_comb begin
        take_clip = (issue_take == 2'd3) ? 2'd2 : issue_take;
        eff_take  = (OW'(take_clip) > occ) ? occ : OW'(take_clip);
        occ_after = occ - eff_take;
        enq       = !redirect_valid && (occ_after <= OW'(DEPTH - 2));
    end

    // Control state: pointers, occupancy and fetch PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        end else begin
            head <= head + PW'(eff_take);
            occ  <= occ_after + (enq ? OW'(2) : OW'(0));
            if (enq) begin
                tail     <= tail + PW'(2);
                fetch_pc <= fetch_pc + 32'd8;
            end
        end
    end

    // Data path: write the fetched pair at tail and tail+1.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            instr_q[tail]  <= imem_data0;
            pc_q[tail]     <= fetch_pc;
            instr_q[tail1] <= imem_data1;
            pc_q[tail1]    <= fetch_pc + 32'd4;
        end
    end

    // Issue view is read straight out of storage; empty slots show a NOP.
    always_comb begin
        issue_valid0 = (occ != '0);
        issue_valid1 = (occ >= OW'(2));
        issue_instr0 = issue_valid0 ? instr_q[head]  : NOP_INSTR;
        issue_pc0    = issue_valid0 ? pc_q[head]     : 32'd0;
        issue_instr1 = issue_valid1 ? instr_q[head1] : NOP_INSTR;
        issue_pc1    = issue_valid1 ? pc_q[head1]    : 32'd0;
    end

endmodule
